mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: ACK_TIMEOUT, default 16, maximum WAIT cycles before a bus error is declared (range 2..255).
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: mem_pc_plus_4_i, mem_alu_result_i, mem_read_data2_i  in  32 each  EX/MEM payload: return address, effective address / ALU value, store data.
REQ-005 Port: mem_rd_addr_i  in  5; mem_funct3_i  in  3  destination register; access size/sign (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-006 Port: mem_reg_write_en_i, mem_mem_read_en_i, mem_mem_write_en_i  in  1 each; mem_mem_to_reg_i  in  2  EX/MEM control.
REQ-007 Port: dmem_req_o, dmem_we_o  out  1; dmem_addr_o, dmem_wdata_o  out  32; dmem_be_o  out  4  data-memory request.
REQ-008 Port: dmem_ack_i  in  1; dmem_rdata_i  in  32  memory completion and word-aligned read data.
REQ-009 Port: stall_o  out  1  holds PC, IF/ID, ID/EX, EX/MEM while an access is outstanding.
REQ-010 Port: wb_pc_plus_4_o, wb_alu_result_o, wb_load_data_o  out  32; wb_rd_addr_o  out  5; wb_reg_write_en_o  out  1; wb_mem_to_reg_o  out  2  registered MEM/WB outputs.
REQ-011 Port: bus_err_o  out  1  one-cycle pulse on timeout; misalign_o  out  1  one-cycle pulse on misaligned access.

Function
REQ-012 FSM states IDLE and WAIT only; IDLE on reset.
REQ-013 IDLE with read or write enable: dmem_req_o=1 combinationally, stall_o=1, go to WAIT unless dmem_ack_i=1 the same cycle (zero-wait completion, stay IDLE, stall_o=0).
REQ-014 WAIT: dmem_req_o held 1, address/data/be/we stable (driven from stalled EX/MEM inputs), stall_o=1 until the dmem_ack_i cycle; then stall_o=0 and return to IDLE.
REQ-015 dmem_addr_o = {mem_alu_result_i[31:2],2'b00}; dmem_we_o = mem_mem_write_en_i.
REQ-016 Stores: dmem_be_o byte=0001<<addr[1:0], half=0011<<addr[1:0], word=1111; dmem_wdata_o = store data replicated across lanes (byte x4, half x2).
REQ-017 Loads: select lane by addr[1:0], sign-extend for LB/LH, zero-extend for LBU/LHU; dmem_be_o=1111 on loads.
REQ-018 MEM/WB register loads on every cycle stall_o=0; while stall_o=1 it loads a bubble (wb_reg_write_en_o=0, wb_rd_addr_o=0).
REQ-019 Instructions without memory access pass to MEM/WB in one cycle with no stall; wb_load_data_o=0.
REQ-020 Timeout: cycle counter (8 bits) counts WAIT cycles; on reaching ACK_TIMEOUT without ack, pulse bus_err_o, return to IDLE, pass instruction with wb_reg_write_en_o forced 0; stores dropped.
REQ-021 Ack and timeout in the same cycle: ack wins, no bus_err_o.
REQ-022 dmem_ack_i while IDLE with no request is ignored.
REQ-023 Read and write enable both 1: treated as write; read data discarded.

Reset
REQ-024 rst=1 at a clock edge: state IDLE, counter 0, all wb_* outputs 0, bus_err_o=0, misalign_o=0; combinational dmem_req_o and stall_o are 0 while rst=1.
REQ-025 rst asserted during WAIT abandons the access; an ack arriving in the first cycle after reset is ignored.

Configuration
REQ-026 Macro MEM_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=00 issues no request, pulses misalign_o, passes with wb_reg_write_en_o=0.
REQ-027 Macro undefined: misalign_o tied 0; misaligned addresses truncate to naturally aligned (addr[0] cleared for half, addr[1:0] for word).

Structure
REQ-028 Shared package holds funct3 size encodings, mem_to_reg encodings, FSM state typedef and default ACK_TIMEOUT.
REQ-029 One sub-module, load_align_ext, for combinational lane select and sign/zero extension.

Verification
REQ-030 LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall_o high 3 cycles, wb_load_data_o=0xDEADBEEF, bubbles during stall.
REQ-031 SB addr 0x103, data 0x000000A5, ack same cycle -> dmem_be_o=1000, wdata 0xA5A5A5A5, no stall.
REQ-032 LB addr 0x102, rdata 0x0080FF00 -> wb_load_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 LW, no ack, ACK_TIMEOUT=16 -> bus_err_o pulse after 16 WAIT cycles, wb_reg_write_en_o=0, FSM IDLE.
REQ-034 LH addr 0x101 with MEM_MISALIGN_TRAP_EN -> no dmem_req_o, misalign_o pulse; without macro -> request to 0x100, lower half returned.
REQ-035 rst asserted in WAIT cycle 2, ack the next cycle -> IDLE, outputs 0, ack ignored.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: funct3 size codes, mem_to_reg codes, FSM state type and default ack timeout
package mem_access_stage_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;
  localparam int ACK_TIMEOUT_DEF = 16;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// load_align_ext: picks the addressed lane of a read word and sign/zero extends it by funct3
module load_align_ext
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [31:0] lane;
  logic        sx;
  always_comb begin
    lane = rdata >> {off, 3'b000};
    sx = ~funct3[2];
    data = funct3[1:0] == SZ_BYTE ? {{24{sx & lane[7]}}, lane[7:0]} :
           funct3[1:0] == SZ_HALF ? {{16{sx & lane[15]}}, lane[15:0]} : lane;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with stalling data-memory handshake, ack timeout, MEM/WB register; MEM_MISALIGN_TRAP_EN enables misaligned-access trap
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc_plus_4_i,
  input  logic [31:0] mem_alu_result_i,
  input  logic [31:0] mem_read_data2_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic        mem_reg_write_en_i,
  input  logic        mem_mem_read_en_i,
  input  logic        mem_mem_write_en_i,
  input  logic [1:0]  mem_mem_to_reg_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        stall_o,
  output logic [31:0] wb_pc_plus_4_o,
  output logic [31:0] wb_alu_result_o,
  output logic [31:0] wb_load_data_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_reg_write_en_o,
  output logic [1:0]  wb_mem_to_reg_o,
  output logic        bus_err_o,
  output logic        misalign_o
);
  state_t      state;
  logic [7:0]  cnt;
  logic [1:0]  sz, off;
  logic        is_mem, trap, access, ack, tmo, is_load;
  logic [31:0] ld_data;
`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem & (sz == SZ_HALF ? mem_alu_result_i[0] : sz != SZ_BYTE && |mem_alu_result_i[1:0]);
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    sz = mem_funct3_i[1:0];
    off = sz == SZ_BYTE ? mem_alu_result_i[1:0] : sz == SZ_HALF ? {mem_alu_result_i[1], 1'b0} : 2'b00;
    is_mem = mem_mem_read_en_i | mem_mem_write_en_i;
    is_load = mem_mem_read_en_i & ~mem_mem_write_en_i;
    access = is_mem & ~trap & ~rst;
    ack = access & dmem_ack_i;
    tmo = access & ~ack & state == S_WAIT & cnt == 8'(ACK_TIMEOUT - 1);
    stall_o = access & ~ack & ~tmo;
    dmem_req_o = access;
    dmem_we_o = mem_mem_write_en_i;
    dmem_addr_o = {mem_alu_result_i[31:2], 2'b00};
    dmem_be_o = ~mem_mem_write_en_i ? 4'b1111 : sz == SZ_BYTE ? 4'b0001 << off :
                sz == SZ_HALF ? 4'b0011 << off : 4'b1111;
    dmem_wdata_o = sz == SZ_BYTE ? {4{mem_read_data2_i[7:0]}} :
                   sz == SZ_HALF ? {2{mem_read_data2_i[15:0]}} : mem_read_data2_i;
  end
  load_align_ext u_ext (
    .rdata  (dmem_rdata_i),
    .off    (off),
    .funct3 (mem_funct3_i),
    .data   (ld_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      wb_pc_plus_4_o <= '0;
      wb_alu_result_o <= '0;
      wb_load_data_o <= '0;
      wb_rd_addr_o <= '0;
      wb_reg_write_en_o <= 1'b0;
      wb_mem_to_reg_o <= '0;
      bus_err_o <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state <= stall_o ? S_WAIT : S_IDLE;
      cnt <= state == S_WAIT && stall_o ? cnt + 8'd1 : 8'd0;
      wb_pc_plus_4_o <= stall_o ? '0 : mem_pc_plus_4_i;
      wb_alu_result_o <= stall_o ? '0 : mem_alu_result_i;
      wb_load_data_o <= ack && is_load ? ld_data : '0;
      wb_rd_addr_o <= stall_o ? '0 : mem_rd_addr_i;
      wb_reg_write_en_o <= ~stall_o & mem_reg_write_en_i & ~tmo & ~trap;
      wb_mem_to_reg_o <= stall_o ? '0 : mem_mem_to_reg_i;
      bus_err_o <= tmo;
      misalign_o <= trap;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage handshake, lanes, timeout, reset
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_pc_plus_4_i, mem_alu_result_i, mem_read_data2_i;
  logic [4:0]  mem_rd_addr_i;
  logic [2:0]  mem_funct3_i;
  logic        mem_reg_write_en_i, mem_mem_read_en_i, mem_mem_write_en_i;
  logic [1:0]  mem_mem_to_reg_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic [31:0] wb_pc_plus_4_o, wb_alu_result_o, wb_load_data_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_reg_write_en_o;
  logic [1:0]  wb_mem_to_reg_o;
  logic        bus_err_o, misalign_o;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [2:0]  f3;
    logic        rd_en, wr_en, regw;
    logic [1:0]  mtr;
    logic [4:0]  rd;
    logic [31:0] pc4, addr, sdata, rdata;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    int          e_stalls;
    logic        e_we;
    logic [31:0] e_ld;
    logic        e_berr, e_mis;
  } op_t;
  op_t sb[$];
  op_t o;
  always #5 clk = ~clk;
  mem_access_stage dut (
    .clk                (clk),
    .rst                (rst),
    .mem_pc_plus_4_i    (mem_pc_plus_4_i),
    .mem_alu_result_i   (mem_alu_result_i),
    .mem_read_data2_i   (mem_read_data2_i),
    .mem_rd_addr_i      (mem_rd_addr_i),
    .mem_funct3_i       (mem_funct3_i),
    .mem_reg_write_en_i (mem_reg_write_en_i),
    .mem_mem_read_en_i  (mem_mem_read_en_i),
    .mem_mem_write_en_i (mem_mem_write_en_i),
    .mem_mem_to_reg_i   (mem_mem_to_reg_i),
    .dmem_req_o         (dmem_req_o),
    .dmem_we_o          (dmem_we_o),
    .dmem_addr_o        (dmem_addr_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_be_o          (dmem_be_o),
    .dmem_ack_i         (dmem_ack_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .stall_o            (stall_o),
    .wb_pc_plus_4_o     (wb_pc_plus_4_o),
    .wb_alu_result_o    (wb_alu_result_o),
    .wb_load_data_o     (wb_load_data_o),
    .wb_rd_addr_o       (wb_rd_addr_o),
    .wb_reg_write_en_o  (wb_reg_write_en_o),
    .wb_mem_to_reg_o    (wb_mem_to_reg_o),
    .bus_err_o          (bus_err_o),
    .misalign_o         (misalign_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic op_t mk(input logic [2:0] f3, input logic rd_en, input logic wr_en,
                             input logic [31:0] addr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int lat);
    op_t r;
    r.f3 = f3; r.rd_en = rd_en; r.wr_en = wr_en; r.regw = ~wr_en;
    r.mtr = rd_en ? MTR_MEM : MTR_ALU; r.rd = 5'd9; r.pc4 = 32'h0000_1004 + addr;
    r.addr = addr; r.sdata = sdata; r.rdata = rdata; r.lat = lat;
    r.e_req = rd_en | wr_en; r.e_addr = {addr[31:2], 2'b00}; r.e_wdata = sdata; r.e_be = 4'hf;
    r.e_stalls = lat; r.e_we = ~wr_en; r.e_ld = '0; r.e_berr = 1'b0; r.e_mis = 1'b0;
    return r;
  endfunction
  task automatic drive(input op_t x);
    mem_funct3_i = x.f3; mem_mem_read_en_i = x.rd_en; mem_mem_write_en_i = x.wr_en;
    mem_reg_write_en_i = x.regw; mem_mem_to_reg_i = x.mtr; mem_rd_addr_i = x.rd;
    mem_pc_plus_4_i = x.pc4; mem_alu_result_i = x.addr; mem_read_data2_i = x.sdata;
    dmem_rdata_i = x.rdata;
  endtask
  task automatic idle();
    mem_funct3_i = 3'b0; mem_mem_read_en_i = 1'b0; mem_mem_write_en_i = 1'b0;
    mem_reg_write_en_i = 1'b0; mem_mem_to_reg_i = 2'b0; mem_rd_addr_i = 5'd0;
    mem_pc_plus_4_i = '0; mem_alu_result_i = '0; mem_read_data2_i = '0;
    dmem_rdata_i = '0; dmem_ack_i = 1'b0;
  endtask
  task automatic run(input op_t x);
    op_t e;
    int stalls = 0;
    logic done = 1'b0;
    sb.push_back(x);
    drive(x);
    for (int k = 0; k < 64 && !done; k++) begin
      dmem_ack_i = (k == x.lat);
      #1;
      chk("req", 32'(dmem_req_o), 32'(x.e_req));
      if (x.e_req) begin
        chk("addr", dmem_addr_o, x.e_addr);
        chk("be", 32'(dmem_be_o), 32'(x.e_be));
        chk("wdata", dmem_wdata_o, x.e_wdata);
        chk("we", 32'(dmem_we_o), 32'(x.wr_en));
      end
      if (stall_o) begin
        stalls++;
        @(posedge clk); #1;
        chk("bubble_we", 32'(wb_reg_write_en_o), 32'd0);
        chk("bubble_rd", 32'(wb_rd_addr_o), 32'd0);
      end else done = 1'b1;
    end
    chk("completed", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(x.e_stalls));
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("wb_pc4", wb_pc_plus_4_o, e.pc4);
    chk("wb_alu", wb_alu_result_o, e.addr);
    chk("wb_load", wb_load_data_o, e.e_ld);
    chk("wb_rd", 32'(wb_rd_addr_o), 32'(e.rd));
    chk("wb_we", 32'(wb_reg_write_en_o), 32'(e.e_we));
    chk("wb_mtr", 32'(wb_mem_to_reg_o), 32'(e.mtr));
    chk("bus_err", 32'(bus_err_o), 32'(e.e_berr));
    chk("misalign", 32'(misalign_o), 32'(e.e_mis));
    idle();
    @(posedge clk); #1;
    chk("bus_err_end", 32'(bus_err_o), 32'd0);
    chk("misalign_end", 32'(misalign_o), 32'd0);
    chk("stall_idle", 32'(stall_o), 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    idle();
    o = mk(F3_LW, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 0);
    drive(o);
    dmem_ack_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_wb_pc4", wb_pc_plus_4_o, 32'd0);
    chk("rst_wb_we", 32'(wb_reg_write_en_o), 32'd0);
    chk("rst_wb_load", wb_load_data_o, 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    o = mk(F3_LW, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 0);
    o.e_req = 1'b0;
    run(o);
    o = mk(F3_LW, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    o.e_ld = 32'hDEAD_BEEF;
    run(o);
    o = mk(F3_LB, 1'b0, 1'b1, 32'h103, 32'h0000_00A5, 32'h0, 0);
    o.e_be = 4'b1000; o.e_wdata = 32'hA5A5_A5A5;
    run(o);
    o = mk(F3_LB, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0080_FF00, 1);
    o.e_ld = 32'hFFFF_FF80;
    run(o);
    o = mk(F3_LBU, 1'b1, 1'b0, 32'h102, 32'h0, 32'h0080_FF00, 1);
    o.e_ld = 32'h0000_0080;
    run(o);
    o = mk(F3_LH, 1'b0, 1'b1, 32'h102, 32'h1234_BEEF, 32'h0, 2);
    o.e_be = 4'b1100; o.e_wdata = 32'hBEEF_BEEF;
    run(o);
    o = mk(F3_LHU, 1'b1, 1'b0, 32'h202, 32'h0, 32'h8001_7FFF, 0);
    o.e_ld = 32'h0000_8001;
    run(o);
    o = mk(F3_LH, 1'b1, 1'b0, 32'h202, 32'h0, 32'h8001_7FFF, 2);
    o.e_ld = 32'hFFFF_8001;
    run(o);
    o = mk(F3_LW, 1'b1, 1'b1, 32'h104, 32'h3333_4444, 32'hFFFF_FFFF, 0);
    run(o);
    o = mk(F3_LH, 1'b1, 1'b0, 32'h101, 32'h0, 32'h1234_ABCD, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    o.e_req = 1'b0; o.e_we = 1'b0; o.e_mis = 1'b1;
`else
    o.e_ld = 32'hFFFF_ABCD;
`endif
    run(o);
    o = mk(F3_LW, 1'b1, 1'b0, 32'h200, 32'h0, 32'h55, -1);
    drive(o);
    dmem_ack_i = 1'b0;
    #1;
    chk("wait_stall", 32'(stall_o), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_wait_req", 32'(dmem_req_o), 32'd0);
    chk("rst_wait_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    dmem_ack_i = 1'b1;
    #1;
    chk("post_rst_req", 32'(dmem_req_o), 32'd0);
    chk("post_rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    dmem_ack_i = 1'b0;
    chk("post_rst_load", wb_load_data_o, 32'd0);
    chk("post_rst_we", 32'(wb_reg_write_en_o), 32'd0);
    chk("post_rst_berr", 32'(bus_err_o), 32'd0);
    o = mk(F3_LW, 1'b1, 1'b0, 32'h300, 32'h0, 32'h77, -1);
    o.e_stalls = 16; o.e_we = 1'b0; o.e_berr = 1'b1;
    run(o);
    o = mk(F3_LW, 1'b1, 1'b0, 32'h304, 32'h0, 32'hCAFE_F00D, 16);
    o.e_ld = 32'hCAFE_F00D;
    run(o);
    o = mk(F3_LW, 1'b1, 1'b0, 32'h308, 32'h0, 32'h0BAD_CAFE, 0);
    o.e_ld = 32'h0BAD_CAFE;
    run(o);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
